// File: rtl/wb_obi_bridge.sv
// -----------------------------------------------------------------------------
// wb_obi_bridge
//
// Wishbone classic-cycle slave that forwards each access as a single OBI
// master transaction. Only one transfer is ever outstanding. The WB address
// is offset by ADDR_OFFSET before it goes out on OBI.
//
// If the WB master walks away (drops wb_cyc_i), or a WB-side timeout fires,
// the transfer is marked "abandoned". The OBI side is still allowed to finish,
// so the OBI protocol is never violated. Its response is then thrown away.
//
// Parameters
//   ADDR_W       address width
//   DATA_W       data width, a multiple of 8
//   ADDR_OFFSET  added to wb_adr_i to form obi_addr_o (wraps modulo 2^ADDR_W)
//   TIMEOUT      busy cycles before a WB error response; 0 disables it
//
// Ports
//   clk_i, rst_ni          clock (rising edge), asynchronous active-low reset
//   wb_cyc_i .. wb_dat_i   WB slave request
//   wb_dat_o               WB read data (last OBI response data)
//   wb_ack_o, wb_err_o     WB single-cycle response pulses
//   obi_req_o .. obi_wdata_o   OBI address phase (registered, held until grant)
//   obi_gnt_i              OBI grant
//   obi_rvalid_i, obi_rdata_i, obi_err_i   OBI response phase
// -----------------------------------------------------------------------------
module wb_obi_bridge #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [ADDR_W-1:0] ADDR_OFFSET = 32'h0,
    parameter logic [15:0]       TIMEOUT     = 16'd255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [DATA_W/8-1:0]   wb_sel_i,
    input  logic [ADDR_W-1:0]     wb_adr_i,
    input  logic [DATA_W-1:0]     wb_dat_i,
    output logic [DATA_W-1:0]     wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_W-1:0]     obi_addr_o,
    output logic                  obi_we_o,
    output logic [DATA_W/8-1:0]   obi_be_o,
    output logic [DATA_W-1:0]     obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [DATA_W-1:0]     obi_rdata_i,
    input  logic                  obi_err_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a WB strobe
    localparam logic [1:0] ST_REQ  = 2'd1;  // OBI address phase, waiting for grant
    localparam logic [1:0] ST_RESP = 2'd2;  // waiting for OBI rvalid
    localparam logic [1:0] ST_DONE = 2'd3;  // issue the WB ack or err pulse

    logic [1:0]  state_q;
    logic        abandon_q;   // WB side no longer wants the result
    logic        err_q;       // error bit of the last OBI response
    logic [15:0] cnt_q;       // busy cycles of the current transfer

    logic busy;
    logic accept;
    logic rsp_take;
    logic wb_gone;
    logic cnt_hit;
    logic timeout_fire;

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (here unconditionally), otherwise synthesis infers a latch.
    always_comb begin
        busy     = (state_q == ST_REQ) || (state_q == ST_RESP);
        // While ack/err is on the bus the master has not yet seen it, so the
        // still-high strobe belongs to the transfer that just finished.
        accept   = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i &&
                   !wb_ack_o && !wb_err_o;
        rsp_take = (state_q == ST_RESP) && obi_rvalid_i;
        wb_gone  = busy && !abandon_q && !wb_cyc_i;
        // The counter reaches TIMEOUT on this edge.
        cnt_hit  = (TIMEOUT != 16'd0) && ((cnt_q + 16'd1) == TIMEOUT);
        // A response arriving on the same edge wins over the timeout; a
        // master that already left gets no error either.
        timeout_fire = busy && !abandon_q && wb_cyc_i && cnt_hit && !rsp_take;
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every read in this block sees the value from before the clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the datapath registers are reset too: they drive ports
            // directly and must read as zero while the block is in reset.
            state_q     <= ST_IDLE;
            abandon_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= 16'd0;
            obi_req_o   <= 1'b0;
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
        end else begin
            // Response strobes are single-cycle pulses by default.
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        obi_addr_o  <= wb_adr_i + ADDR_OFFSET;
                        obi_we_o    <= wb_we_i;
                        obi_be_o    <= wb_sel_i;
                        obi_wdata_o <= wb_dat_i;
                        obi_req_o   <= 1'b1;
                        abandon_q   <= 1'b0;
                        cnt_q       <= 16'd0;
                        state_q     <= ST_REQ;
                    end
                end

                ST_REQ, ST_RESP: begin
                    // WB-side supervision runs in both busy states and never
                    // touches the OBI handshake.
                    if (!abandon_q) begin
                        cnt_q <= cnt_q + 16'd1;
                        if (wb_gone) begin
                            abandon_q <= 1'b1;
                        end else if (timeout_fire) begin
                            abandon_q <= 1'b1;
                            wb_err_o  <= 1'b1;
                        end
                    end

                    if (state_q == ST_REQ) begin
                        // Request stays up until granted, even if abandoned.
                        if (obi_gnt_i) begin
                            obi_req_o <= 1'b0;
                            state_q   <= ST_RESP;
                        end
                    end else if (rsp_take) begin
                        wb_dat_o <= obi_rdata_i;
                        err_q    <= obi_err_i;
                        // A master that left on this very edge also gets
                        // nothing back.
                        if (abandon_q || !wb_cyc_i) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    if (err_q) begin
                        wb_err_o <= 1'b1;
                    end else begin
                        wb_ack_o <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
